// File: rtl/fpu_result_accum.sv
// Batch accumulator for the fpu add/compare stage: sums COUNT samples of z, counts s flags,
// and holds the result behind a valid/ready handshake. Define FPU_ACC_SAT_EN to saturate on overflow.
module fpu_result_accum #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned COUNT = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_z,
    input  logic             in_s,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_gt_cnt,
    output logic             out_ovf,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] L_MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] L_MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] L_COUNT   = CNT_W'(COUNT);
    localparam bit               L_SINGLE  = (COUNT == 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_gt;
    logic [CNT_W-1:0] r_n;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic             w_accept;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf_now;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_next;

    assign w_accept  = in_valid && r_in_ready;
    assign w_sum     = r_acc + in_z;
    // Same-sign operands with a differently signed result mean the signed add overflowed.
    assign w_ovf_now = (r_acc[WIDTH-1] == in_z[WIDTH-1]) && (w_sum[WIDTH-1] != r_acc[WIDTH-1]);
    assign w_last    = (r_n + CNT_W'(1)) == L_COUNT;

`ifdef FPU_ACC_SAT_EN
    assign w_acc_next = w_ovf_now ? (r_acc[WIDTH-1] ? L_MAX_NEG : L_MAX_POS) : w_sum;
`else
    assign w_acc_next = w_sum;
`endif

    // Batch FSM; handshake flags are registered alongside the state they decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_gt        <= '0;
            r_n         <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc  <= in_z;
                        r_gt   <= CNT_W'(in_s);
                        r_ovf  <= 1'b0;
                        r_n    <= CNT_W'(1);
                        r_busy <= 1'b1;
                        if (L_SINGLE) begin
                            r_state     <= S_HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        r_gt  <= r_gt + CNT_W'(in_s);
                        r_ovf <= r_ovf | w_ovf_now;
                        r_n   <= r_n + CNT_W'(1);
                        if (w_last) begin
                            r_state     <= S_HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_n         <= '0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_n         <= '0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_sum    = r_acc;
    assign out_gt_cnt = r_gt;
    assign out_ovf    = r_ovf;
    assign busy       = r_busy;

endmodule

// File: tb/tb_fpu_result_accum.sv
// Directed bench for fpu_result_accum (COUNT=4); expectations follow FPU_ACC_SAT_EN when defined.
module tb_fpu_result_accum;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned COUNT = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_z;
    logic             in_s;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_sum;
    logic [CNT_W-1:0] out_gt_cnt;
    logic             out_ovf;
    logic             out_ready;
    logic             busy;

    int n_total = 0;
    int n_bad   = 0;

    fpu_result_accum #(.WIDTH(WIDTH), .COUNT(COUNT), .CNT_W(CNT_W)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_z       (in_z),
        .in_s       (in_s),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_sum    (out_sum),
        .out_gt_cnt (out_gt_cnt),
        .out_ovf    (out_ovf),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // One cycle of input: drive after the falling edge, consumed at the next rising edge.
    task automatic cyc(input logic v, input logic [WIDTH-1:0] z, input logic s);
        @(negedge clk);
        in_valid = v;
        in_z     = z;
        in_s     = s;
        @(posedge clk);
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
        in_z     = 32'hDEAD_BEEF;
        in_s     = 1'b1;
    endtask

    task automatic check_hold(input string tag, input logic [31:0] sum, input logic [31:0] gt,
                              input logic ovf);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_rdy"},   32'(in_ready),  32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd1);
        chk({tag, "_sum"},   out_sum,        sum);
        chk({tag, "_gt"},    32'(out_gt_cnt), gt);
        chk({tag, "_ovf"},   32'(out_ovf),   32'(ovf));
    endtask

    // Pulse out_ready for one edge, then expect the block to be idle and ready.
    task automatic release_hold(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_rel_rdy"},   32'(in_ready),  32'd1);
        chk({tag, "_rel_busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_z      = '0;
        in_s      = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid),  32'd0);
        chk("rst_sum",   out_sum,         32'd0);
        chk("rst_gt",    32'(out_gt_cnt), 32'd0);
        chk("rst_ovf",   32'(out_ovf),    32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_rdy",   32'(in_ready),   32'd1);

        // Basic batch, then backpressure in HOLD.
        cyc(1'b1, 32'd1, 1'b1);
        cyc(1'b1, 32'd2, 1'b0);
        cyc(1'b1, 32'd3, 1'b1);
        chk("acc_valid", 32'(out_valid), 32'd0);
        chk("acc_busy",  32'(busy),      32'd1);
        chk("acc_rdy",   32'(in_ready),  32'd1);
        cyc(1'b1, 32'd4, 1'b1);
        idle_in();
        check_hold("basic", 32'd10, 32'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'd100, 1'b1);
            check_hold($sformatf("bp%0d", i), 32'd10, 32'd3, 1'b0);
        end
        idle_in();
        release_hold("basic");

        // Signed mix without overflow: -3+5-7+2 = -3.
        cyc(1'b1, 32'hFFFF_FFFD, 1'b1);
        cyc(1'b1, 32'd5,         1'b1);
        cyc(1'b1, 32'hFFFF_FFF9, 1'b1);
        cyc(1'b1, 32'd2,         1'b1);
        idle_in();
        check_hold("neg", 32'hFFFF_FFFD, 32'd4, 1'b0);
        release_hold("neg");

        // Positive overflow.
        cyc(1'b1, 32'h7FFF_FFFF, 1'b0);
        cyc(1'b1, 32'd1,         1'b0);
        cyc(1'b1, 32'd0,         1'b0);
        cyc(1'b1, 32'd0,         1'b0);
        idle_in();
`ifdef FPU_ACC_SAT_EN
        check_hold("povf", 32'h7FFF_FFFF, 32'd0, 1'b1);
`else
        check_hold("povf", 32'h8000_0000, 32'd0, 1'b1);
`endif
        release_hold("povf");

        // Negative overflow.
        cyc(1'b1, 32'h8000_0000, 1'b1);
        cyc(1'b1, 32'hFFFF_FFFF, 1'b0);
        cyc(1'b1, 32'd0,         1'b0);
        cyc(1'b1, 32'd0,         1'b0);
        idle_in();
`ifdef FPU_ACC_SAT_EN
        check_hold("novf", 32'h8000_0000, 32'd1, 1'b1);
`else
        check_hold("novf", 32'h7FFF_FFFF, 32'd1, 1'b1);
`endif
        release_hold("novf");

        // Gaps in in_valid: 1,0,1,0,0,1,1 -> four accepts; ovf from previous batch is cleared.
        cyc(1'b1, 32'd5, 1'b0);
        cyc(1'b0, 32'd9, 1'b1);
        cyc(1'b1, 32'd5, 1'b0);
        cyc(1'b0, 32'd9, 1'b1);
        cyc(1'b0, 32'd9, 1'b1);
        cyc(1'b1, 32'd5, 1'b0);
        cyc(1'b1, 32'd5, 1'b0);
        idle_in();
        check_hold("gap", 32'd20, 32'd0, 1'b0);
        release_hold("gap");

        // Mid-batch reset discards the partial batch.
        cyc(1'b1, 32'd7, 1'b1);
        cyc(1'b1, 32'd7, 1'b1);
        idle_in();
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid),  32'd0);
        chk("mrst_sum",   out_sum,         32'd0);
        chk("mrst_gt",    32'(out_gt_cnt), 32'd0);
        chk("mrst_ovf",   32'(out_ovf),    32'd0);
        chk("mrst_busy",  32'(busy),       32'd0);
        chk("mrst_rdy",   32'(in_ready),   32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'd1, 1'b0);
        idle_in();
        check_hold("post", 32'd4, 32'd0, 1'b0);
        release_hold("post");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
